// File: rtl/dbus_pkg.sv
// dbus_pkg: shared types and helpers for the dBus router.
//   tgt_e      - decoded bus target (memory, peripheral bank, JTAG UART, unmapped)
//   state_e    - router FSM states
//   REGION_*   - address nibble [31:28] selecting the non-memory regions
//   be_calc()  - byte-enable generation from access size and address offset
package dbus_pkg;

  typedef enum logic [1:0] {
    TGT_MEM    = 2'd0,
    TGT_PERIPH = 2'd1,
    TGT_JUART  = 2'd2,
    TGT_NONE   = 2'd3
  } tgt_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_PEND = 2'd1,
    ERR_RSP = 2'd2
  } state_e;

  localparam logic [3:0] REGION_PERIPH = 4'h8;
  localparam logic [3:0] REGION_JUART  = 4'h9;

  // Lanes shifted past bit 3 fall off; misaligned accesses are the CPU's problem.
  function automatic logic [3:0] be_calc(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] be;
    case (size)
      2'd0:    be = 4'b0001 << offset;
      2'd1:    be = 4'b0011 << offset;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dbus_addr_decode.sv
// dbus_addr_decode: combinational address-to-target decode.
//   region  in  [3:0]  cmd_addr[31:28]
//   tgt     out tgt_e  decoded target
// Only the top nibble matters, so only that is brought in.
module dbus_addr_decode
  import dbus_pkg::*;
(
  input  logic [3:0] region,
  output tgt_e       tgt
);

  always_comb begin
    tgt = TGT_NONE;
    if (!region[3])                  tgt = TGT_MEM;
    else if (region == REGION_PERIPH) tgt = TGT_PERIPH;
    else if (region == REGION_JUART)  tgt = TGT_JUART;
  end

endmodule

// File: rtl/dbus_router.sv
// dbus_router: steers the CPU simple data bus to memory, peripheral bank and
// JTAG UART; allows one outstanding read; unmapped or timed-out reads get an
// error response so the CPU never stalls.
//   clk, reset                    clock, synchronous active-high reset
//   cmd_*                         CPU command (valid/ready/wr/addr/data/size)
//   rsp_ready/rsp_error/rsp_data  single-cycle read response to the CPU
//   tgt_addr/tgt_wr/tgt_wdata/tgt_be  shared command fields to all targets
//   {mem,periph,juart}_cmd_*      per-target command strobe / accept
//   {mem,periph,juart}_rsp_*      per-target read data
//   err_count                     saturating count of error events
//   busy                          high while not idle
module dbus_router
  import dbus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic [1:0]  cmd_size,
  output logic        rsp_ready,
  output logic        rsp_error,
  output logic [31:0] rsp_data,
  output logic [31:0] tgt_addr,
  output logic        tgt_wr,
  output logic [31:0] tgt_wdata,
  output logic [3:0]  tgt_be,
  output logic        mem_cmd_valid,
  output logic        periph_cmd_valid,
  output logic        juart_cmd_valid,
  input  logic        mem_cmd_ready,
  input  logic        periph_cmd_ready,
  input  logic        juart_cmd_ready,
  input  logic        mem_rsp_valid,
  input  logic        periph_rsp_valid,
  input  logic        juart_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic [31:0] periph_rsp_data,
  input  logic [31:0] juart_rsp_data,
  output logic [7:0]  err_count,
  output logic        busy
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q,   state_d;
  tgt_e        cur_tgt_q, cur_tgt_d;
  logic [15:0] cnt_q,     cnt_d;
  logic [7:0]  err_count_q, err_count_d;

  tgt_e        dec_tgt;
  logic        cur_rsp_valid;
  logic [31:0] cur_rsp_data;
  logic        stray;
  logic        err_ev;

  dbus_addr_decode u_decode (
    .region (cmd_addr[31:28]),
    .tgt    (dec_tgt)
  );

  assign tgt_addr  = cmd_addr;
  assign tgt_wr    = cmd_wr;
  assign tgt_wdata = cmd_data;
  assign tgt_be    = be_calc(cmd_size, cmd_addr[1:0]);
  assign err_count = err_count_q;
  assign busy      = (state_q != IDLE);

  // Response of the target that owns the pending read, plus everything else
  // that shows up uninvited (including anything outside RD_PEND).
  always_comb begin
    cur_rsp_valid = 1'b0;
    cur_rsp_data  = 32'd0;
    case (cur_tgt_q)
      TGT_MEM:    begin cur_rsp_valid = mem_rsp_valid;    cur_rsp_data = mem_rsp_data;    end
      TGT_PERIPH: begin cur_rsp_valid = periph_rsp_valid; cur_rsp_data = periph_rsp_data; end
      TGT_JUART:  begin cur_rsp_valid = juart_rsp_valid;  cur_rsp_data = juart_rsp_data;  end
      default:    ;
    endcase
    if (state_q == RD_PEND) begin
      stray = (mem_rsp_valid    && cur_tgt_q != TGT_MEM)
           || (periph_rsp_valid && cur_tgt_q != TGT_PERIPH)
           || (juart_rsp_valid  && cur_tgt_q != TGT_JUART);
    end else begin
      stray = mem_rsp_valid || periph_rsp_valid || juart_rsp_valid;
    end
  end

  always_comb begin
    state_d          = state_q;
    cur_tgt_d        = cur_tgt_q;
    cnt_d            = cnt_q;
    err_ev           = stray;
    cmd_ready        = 1'b0;
    mem_cmd_valid    = 1'b0;
    periph_cmd_valid = 1'b0;
    juart_cmd_valid  = 1'b0;
    rsp_ready        = 1'b0;
    rsp_error        = 1'b0;
    rsp_data         = 32'd0;

    case (state_q)
      IDLE: begin
        case (dec_tgt)
          TGT_MEM:    begin mem_cmd_valid    = cmd_valid; cmd_ready = mem_cmd_ready;    end
          TGT_PERIPH: begin periph_cmd_valid = cmd_valid; cmd_ready = periph_cmd_ready; end
          TGT_JUART:  begin juart_cmd_valid  = cmd_valid; cmd_ready = juart_cmd_ready;  end
          default:    cmd_ready = 1'b1;  // unmapped: swallow so the CPU moves on
        endcase
        if (cmd_valid && cmd_ready) begin
          if (dec_tgt == TGT_NONE) begin
            err_ev = 1'b1;
            if (!cmd_wr) state_d = ERR_RSP;
          end else if (!cmd_wr) begin
            state_d   = RD_PEND;
            cur_tgt_d = dec_tgt;
            cnt_d     = 16'd0;
          end
        end
      end
      RD_PEND: begin
        // A response in the timeout cycle still wins.
        if (cur_rsp_valid) begin
          rsp_ready = 1'b1;
          rsp_data  = cur_rsp_data;
          state_d   = IDLE;
        end else if (cnt_q == TMO_LAST) begin
          err_ev  = 1'b1;
          state_d = ERR_RSP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ERR_RSP: begin
        rsp_ready = 1'b1;
        rsp_error = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Any number of error events in one cycle counts once.
    err_count_d = err_count_q;
    if (err_ev && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_tgt_q   <= TGT_NONE;
      cnt_q       <= 16'd0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cur_tgt_q   <= cur_tgt_d;
      cnt_q       <= cnt_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: doc/dbus_router.md
# dbus_router

Routes the VexRiscv simple data bus (dBus) to three targets: on-chip memory, the peripheral register bank, and the JTAG UART. It enforces at most one outstanding read and steers the read response back to the CPU. Unmapped accesses and hung targets complete with an error response, so the CPU never stalls forever. It sits between the CPU's dBus and the per-target logic in the top level, replacing ad-hoc select/ready/rsp muxing.

## Interface
- TIMEOUT_CYCLES, 255: cycles a pending read may wait before an error response is forced; legal range 2..65535.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  CPU dBus command valid
- cmd_ready  out  1  command accepted this cycle when high together with cmd_valid
- cmd_wr  in  1  1 = write, 0 = read
- cmd_addr  in  32  byte address
- cmd_data  in  32  write data
- cmd_size  in  2  0 = byte, 1 = half, 2/3 = word
- rsp_ready  out  1  read response valid (single-cycle pulse)
- rsp_error  out  1  qualifies rsp_ready; response is an error
- rsp_data  out  32  read data
- tgt_addr  out  32  cmd_addr pass-through to all targets
- tgt_wr  out  1  cmd_wr pass-through
- tgt_wdata  out  32  cmd_data pass-through
- tgt_be  out  4  byte enables
- {mem,periph,juart}_cmd_valid  out  1 each  per-target command strobe
- {mem,periph,juart}_cmd_ready  in  1 each  per-target accept; mem and periph are normally tied high
- {mem,periph,juart}_rsp_valid  in  1 each  per-target read data valid
- {mem,periph,juart}_rsp_data  in  32 each  per-target read data
- err_count  out  8  saturating count of error events
- busy  out  1  high while a read is pending

## Operation
**Address decode** (cmd_addr):
- [31]=0 → MEM.
- [31:28]=4'h8 → PERIPH.
- [31:28]=4'h9 → JUART.
- Anything else → NONE.

**Byte enables (tgt_be):**
- size 0: 4'b0001 << addr[1:0].
- size 1: 4'b0011 << addr[1:0].
- Otherwise 4'b1111.
- Computed combinationally in every cycle.

**FSM states:**
- IDLE: x_cmd_valid = cmd_valid && decoded target x. cmd_ready = x_cmd_ready of the decoded target; for NONE, cmd_ready = 1.
  - Accepted write to MEM/PERIPH/JUART: stay in IDLE. Writes have no response.
  - Accepted write to NONE: dropped, err_count+1, stay in IDLE.
  - Accepted read to a target: latch target into cur_tgt, clear timeout counter, go to RD_PEND.
  - Accepted read to NONE: go to ERR_RSP, err_count+1.
- RD_PEND: cmd_ready=0 and all x_cmd_valid=0.
  - cur_tgt rsp_valid=1: rsp_ready=1, rsp_error=0, rsp_data=that target's rsp_data (combinational), go to IDLE.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1 with no rsp_valid, go to ERR_RSP and err_count+1.
- ERR_RSP: rsp_ready=1, rsp_error=1, rsp_data=0 for exactly one cycle; cmd_ready=0; go to IDLE.

**Boundary rules:**
- rsp_valid from a target other than cur_tgt, or any rsp_valid in IDLE or ERR_RSP: ignored, err_count+1.
- rsp_valid arriving in the same cycle the timeout expires: the response wins and no error is raised.
- A late response after a timeout: counted as stray, never forwarded.
- err_count saturates at 255; simultaneous error events count as one.
- Reset mid-read: state returns to IDLE and any subsequent late response is treated as stray.

**Reset values:** state IDLE, counter 0, err_count 0, busy 0. rsp_ready and rsp_error are 0 whenever not driven by a response.

busy = (state != IDLE).

## Timing
- Command path is combinational: x_cmd_valid and cmd_ready have zero latency from cmd_valid/cmd_addr.
- A target with a 1-cycle read latency gives: accept in cycle N, rsp_ready in N+1, next command accepted no earlier than N+2.
- Unmapped read: accept in N, error response in N+1.
- Timeout: accept in N, error response in N+TIMEOUT_CYCLES+1.
- JUART backpressure: cmd_ready follows juart_cmd_ready. The command is held by the CPU (cmd_valid, cmd_addr, cmd_wr, cmd_data, cmd_size stable until accepted).
- rsp_data is valid only while rsp_ready=1; it is otherwise undefined but must not contain X in simulation.

## Structure
- Package dbus_pkg holds:
  - target enum: TGT_MEM, TGT_PERIPH, TGT_JUART, TGT_NONE.
  - FSM state enum: IDLE, RD_PEND, ERR_RSP.
  - Region constants: REGION_PERIPH=4'h8, REGION_JUART=4'h9.
  - Byte-enable function.
- Sub-module dbus_addr_decode: purely combinational, cmd_addr → target enum. It is shared with testbench scoreboards.

## Test plan
- Word read 0x0000_0010 with mem responding at N+1 with 0x1234_5678 → mem_cmd_valid=1 only, rsp_ready at N+1 with rsp_data=0x1234_5678, rsp_error=0, busy high for 1 cycle.
- Byte write 0x8000_0003, size 0 → periph_cmd_valid=1, tgt_be=4'b1000, no rsp_ready, err_count stays 0.
- Read 0x9000_0004 with juart_cmd_ready held low 5 cycles, then rsp 3 cycles later with 0x0000_00AA → cmd_ready low 5 cycles, then accept, rsp_data=0x0000_00AA.
- Read 0xA000_0000 → rsp_ready=1, rsp_error=1, rsp_data=0 the next cycle, err_count=1; write 0xF000_0000 → err_count=2.
- TIMEOUT_CYCLES=4, periph read with no response → error rsp 5 cycles after accept; a subsequent periph_rsp_valid is ignored and err_count increments.
- Assert reset while in RD_PEND → next cycle busy=0, err_count=0; a following mem read completes normally.
